// File: rtl/counter_pkg.sv
// Shared constants and helpers for the parametrised up/down counter.
package counter_pkg;

    localparam int unsigned CNT_WRAP = 0;
    localparam int unsigned CNT_SAT  = 1;

    // Largest value the counter may hold for a given modulus.
    function automatic int unsigned max_val(input int unsigned modulus);
        return modulus - 1;
    endfunction

    // Out-of-range load values are clamped to the top of the count range.
    function automatic int unsigned clamp_load(input int unsigned value,
                                               input int unsigned modulus);
        return (value < modulus) ? value : (modulus - 1);
    endfunction

endpackage

// File: rtl/counter_next_calc.sv
// Combinational next-count, limit detection and terminal count for the counter.
module counter_next_calc
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MODULUS  = 16,
    parameter int unsigned SATURATE = CNT_WRAP
) (
    input  logic [WIDTH-1:0] q_i,
    input  logic             up_i,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             clear_i,
    output logic [WIDTH-1:0] q_next_c,
    output logic             limit_hit_c,
    output logic             tc_c
);

    // One extra bit so MODULUS == 2**WIDTH compares and steps without truncation.
    localparam int unsigned    CW     = WIDTH + 1;
    localparam logic [CW-1:0]  MAXVAL = CW'(max_val(MODULUS));
    localparam logic [CW-1:0]  ZERO   = '0;
    localparam logic           HOLD   = (SATURATE == CNT_SAT);

    logic [CW-1:0]    q_ext;
    logic [CW-1:0]    q_inc;
    logic [CW-1:0]    q_dec;
    logic             at_max;
    logic             at_min;
    logic [WIDTH-1:0] load_clamped;

    assign q_ext        = {1'b0, q_i};
    assign q_inc        = q_ext + CW'(1);
    assign q_dec        = q_ext - CW'(1);
    assign at_max       = (q_ext == MAXVAL);
    assign at_min       = (q_ext == ZERO);
    assign load_clamped = WIDTH'(clamp_load(32'(load_val_i), MODULUS));
    assign tc_c         = up_i ? at_max : at_min;

    always_comb begin
        q_next_c    = q_i;
        limit_hit_c = 1'b0;
        if (clear_i) begin
            q_next_c = '0;
        end else if (load_i) begin
            q_next_c = load_clamped;
        end else if (en_i) begin
            if (up_i) begin
                if (at_max) begin
                    limit_hit_c = 1'b1;
                    q_next_c    = HOLD ? q_i : '0;
                end else begin
                    q_next_c = WIDTH'(q_inc);
                end
            end else begin
                if (at_min) begin
                    limit_hit_c = 1'b1;
                    q_next_c    = HOLD ? q_i : WIDTH'(MAXVAL);
                end else begin
                    q_next_c = WIDTH'(q_dec);
                end
            end
        end
    end

endmodule

// File: rtl/sync_updown_counter.sv
// Parametrised synchronous up/down counter with wrap/saturate modes,
// cascadable terminal count, one-cycle wrap pulse and sticky overflow.
module sync_updown_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MODULUS  = 16,
    parameter int unsigned SATURATE = CNT_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             wrap_q;
    logic             wrap_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             limit_hit;

    counter_next_calc #(
        .WIDTH    (WIDTH),
        .MODULUS  (MODULUS),
        .SATURATE (SATURATE)
    ) u_next (
        .q_i         (q_q),
        .up_i        (up),
        .en_i        (en),
        .load_i      (load),
        .load_val_i  (load_val),
        .clear_i     (clear),
        .q_next_c    (q_d),
        .limit_hit_c (limit_hit),
        .tc_c        (tc)
    );

    // wrap pulses only on limit events; ovf accumulates until clear or reset.
    always_comb begin
        wrap_d = limit_hit;
        ovf_d  = ovf_q | limit_hit;
        if (clear) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q    <= '0;
            wrap_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
            ovf_q  <= ovf_d;
        end
    end

    assign q    = q_q;
    assign wrap = wrap_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_sync_updown_counter.sv
// Self-checking bench: three counter configurations share one stimulus stream,
// plus a two-stage decade cascade, all compared against a behavioural model.
module tb_sync_updown_counter;

    localparam int NI = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear, load, en, up;
    logic [3:0] load_val;
    logic [3:0] dq  [NI];
    logic       dtc [NI];
    logic       dwr [NI];
    logic       dov [NI];

    logic       c_clear, c_en;
    logic [3:0] lo_q, hi_q;
    logic       lo_tc, hi_tc, lo_wr, hi_wr, lo_ov, hi_ov, hi_en;

    int checks   = 0;
    int failures = 0;

    // Model state: index 0 = mod10 wrap, 1 = mod10 saturate, 2 = mod16 wrap.
    int mods [NI] = '{10, 10, 16};
    bit sats [NI] = '{1'b0, 1'b1, 1'b0};
    int mq   [NI];
    bit mw   [NI];
    bit mo   [NI];
    int casc_n;

    always #5 clk = ~clk;

    sync_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_w10 (
        .clk(clk), .rst(rst), .clear(clear), .load(load), .load_val(load_val),
        .en(en), .up(up), .q(dq[0]), .tc(dtc[0]), .wrap(dwr[0]), .ovf(dov[0]));

    sync_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) u_s10 (
        .clk(clk), .rst(rst), .clear(clear), .load(load), .load_val(load_val),
        .en(en), .up(up), .q(dq[1]), .tc(dtc[1]), .wrap(dwr[1]), .ovf(dov[1]));

    sync_updown_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(0)) u_f16 (
        .clk(clk), .rst(rst), .clear(clear), .load(load), .load_val(load_val),
        .en(en), .up(up), .q(dq[2]), .tc(dtc[2]), .wrap(dwr[2]), .ovf(dov[2]));

    assign hi_en = c_en & lo_tc;

    sync_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_lo (
        .clk(clk), .rst(rst), .clear(c_clear), .load(1'b0), .load_val(4'd0),
        .en(c_en), .up(1'b1), .q(lo_q), .tc(lo_tc), .wrap(lo_wr), .ovf(lo_ov));

    sync_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_hi (
        .clk(clk), .rst(rst), .clear(c_clear), .load(1'b0), .load_val(4'd0),
        .en(hi_en), .up(1'b1), .q(hi_q), .tc(hi_tc), .wrap(hi_wr), .ovf(hi_ov));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            mq[i] = 0; mw[i] = 1'b0; mo[i] = 1'b0;
        end
        casc_n = 0;
    endtask

    // Behavioural rule set: modular stepping, limit = crossing the range end.
    task automatic model_step(input bit c, input bit l, input int lv, input bit e, input bit u);
        for (int i = 0; i < NI; i++) begin
            if (c) begin
                mq[i] = 0; mw[i] = 1'b0; mo[i] = 1'b0;
            end else if (l) begin
                mq[i] = (lv < mods[i]) ? lv : mods[i] - 1;
                mw[i] = 1'b0;
            end else if (e) begin
                int nq;
                bit lim;
                if (u) begin
                    lim = (mq[i] + 1 >= mods[i]);
                    nq  = (mq[i] + 1) % mods[i];
                end else begin
                    lim = (mq[i] == 0);
                    nq  = (mq[i] + mods[i] - 1) % mods[i];
                end
                if (lim && sats[i]) nq = mq[i];
                mq[i] = nq;
                mw[i] = lim;
                mo[i] = mo[i] | lim;
            end else begin
                mw[i] = 1'b0;
            end
        end
        if (c_clear)   casc_n = 0;
        else if (c_en) casc_n = casc_n + 1;
    endtask

    task automatic check_all(input string ph);
        for (int i = 0; i < NI; i++) begin
            bit etc;
            etc = up ? (mq[i] == mods[i] - 1) : (mq[i] == 0);
            check($sformatf("%s.q[%0d]", ph, i),    32'(dq[i]),  32'(mq[i]));
            check($sformatf("%s.wrap[%0d]", ph, i), 32'(dwr[i]), 32'(mw[i]));
            check($sformatf("%s.ovf[%0d]", ph, i),  32'(dov[i]), 32'(mo[i]));
            check($sformatf("%s.tc[%0d]", ph, i),   32'(dtc[i]), 32'(etc));
        end
        check({ph, ".casc_lo"}, 32'(lo_q), 32'(casc_n % 10));
        check({ph, ".casc_hi"}, 32'(hi_q), 32'((casc_n / 10) % 10));
    endtask

    task automatic cycle(input string ph, input bit c, input bit l, input int lv,
                         input bit e, input bit u);
        clear = c; load = l; load_val = 4'(lv); en = e; up = u;
        @(posedge clk);
        model_step(c, l, lv, e, u);
        #1;
        check_all(ph);
    endtask

    // Reset asserted between edges must clear at once and mask the next edge.
    task automatic reset_mid(input string ph);
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        check_all({ph, ".async"});
        @(posedge clk);
        #1;
        check_all({ph, ".held"});
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; load = 1'b0; load_val = 4'd0; en = 1'b0; up = 1'b0;
        c_clear = 1'b0; c_en = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // Count to 5, reset mid-count, then first edge after release gives 1.
        for (int k = 0; k < 5; k++) cycle("pre_rst", 0, 0, 0, 1, 1);
        check("pre_rst.w10_is5", 32'(dq[0]), 32'd5);
        reset_mid("rst_mid");
        cycle("post_rst", 0, 0, 0, 1, 1);
        check("post_rst.w10_is1", 32'(dq[0]), 32'd1);

        // Wrap up through 9 -> 0.
        cycle("clr", 1, 0, 0, 0, 1);
        for (int k = 0; k < 10; k++) cycle("wrap_up", 0, 0, 0, 1, 1);
        check("wrap_up.w10_q0", 32'(dq[0]), 32'd0);
        check("wrap_up.w10_wrap", 32'(dwr[0]), 32'd1);
        check("wrap_up.s10_q9", 32'(dq[1]), 32'd9);
        cycle("wrap_idle", 0, 0, 0, 0, 1);
        check("wrap_idle.w10_wrap0", 32'(dwr[0]), 32'd0);
        check("wrap_idle.w10_ovf1", 32'(dov[0]), 32'd1);

        // Saturate down from a load of 2.
        cycle("clr2", 1, 0, 0, 0, 0);
        cycle("ld2", 0, 1, 2, 0, 0);
        for (int k = 0; k < 4; k++) cycle("sat_dn", 0, 0, 0, 1, 0);
        check("sat_dn.s10_q0", 32'(dq[1]), 32'd0);
        check("sat_dn.s10_wrap", 32'(dwr[1]), 32'd1);
        check("sat_dn.w10_q8", 32'(dq[0]), 32'd8);

        // Priority and load clamping.
        cycle("prio_clr", 1, 1, 7, 1, 1);
        check("prio_clr.q0", 32'(dq[0]), 32'd0);
        cycle("prio_ld", 0, 1, 7, 1, 1);
        check("prio_ld.q7", 32'(dq[0]), 32'd7);
        cycle("ld_clamp", 0, 1, 12, 1, 1);
        check("ld_clamp.w10_q9", 32'(dq[0]), 32'd9);
        check("ld_clamp.f16_q12", 32'(dq[2]), 32'd12);

        // Full-range modulus wrap both ways.
        cycle("ld15", 0, 1, 15, 0, 1);
        cycle("f16_up", 0, 0, 0, 1, 1);
        check("f16_up.q0", 32'(dq[2]), 32'd0);
        check("f16_up.wrap", 32'(dwr[2]), 32'd1);
        cycle("f16_dn", 0, 0, 0, 1, 0);
        check("f16_dn.q15", 32'(dq[2]), 32'd15);

        // Two-stage decade cascade.
        c_clear = 1'b1;
        cycle("casc_clr", 0, 0, 0, 0, 1);
        c_clear = 1'b0;
        c_en    = 1'b1;
        for (int k = 0; k < 25; k++) cycle("casc", 0, 0, 0, 0, 1);
        c_en = 1'b0;
        check("casc.lo5", 32'(lo_q), 32'd5);
        check("casc.hi2", 32'(hi_q), 32'd2);

        // Randomised traffic against the model, with occasional async resets.
        for (int k = 0; k < 400; k++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r == 99) begin
                reset_mid("rnd_rst");
            end else begin
                cycle("rnd", r < 4, (r >= 4) && (r < 18), int'($urandom_range(0, 15)),
                      $urandom_range(0, 9) < 8, 1'($urandom_range(0, 1)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
